if_pc_unit: RTL and testbench
=============================

// Module: if_pc_unit
// PURPOSE
//  Fetch-stage program counter, parametrised successor of the single-register fetch PC.
//  Holds and advances the fetch address, honours stallf, and applies branch/jump redirects and exceptions.
//  Buffers a redirect that arrives while stalled and applies it when the stall releases.
//  Sits between the PC-select logic and the instruction memory address port.
// PARAMETERS
//  XLEN          32            PC width in bits
//  RESET_VECTOR  32'h0040_0030 first fetch address after reset
//  EXC_VECTOR    32'h8000_0180 exception handler entry address
//  PC_STEP       4             sequential increment in bytes
//  ALIGN_BITS    2             low target bits that must be zero (0 disables the check)
// PORTS
//  clk             in   1     single clock; all state updates on posedge
//  reset           in   1     synchronous reset, active-high
//  stallf          in   1     hold fetch PC this cycle
//  redirect_valid  in   1     take redirect_pc (branch/jump resolved)
//  redirect_pc     in   XLEN  redirect target
//  exc_valid       in   1     take exception; overrides stallf and redirects
//  pcfetch         out  XLEN  current fetch address (registered)
//  pcplus          out  XLEN  pcfetch + PC_STEP (combinational, wraps modulo 2^XLEN)
//  fetch_valid     out  1     pcfetch is a valid correct-path fetch (registered)
//  misalign_err    out  1     one-cycle pulse: misaligned redirect was trapped
//  badaddr         out  XLEN  last misaligned target; holds until the next trap
// BEHAVIOUR
//  Reset (sync, active-high) has priority over all inputs. Reset values:
//    pcfetch=RESET_VECTOR, fetch_valid=0, misalign_err=0, badaddr=0, pend_pc=0, state=BOOT.
//  States: BOOT, RUN, PEND.
//  BOOT: one cycle after reset deasserts; pcfetch is not advanced. Next state is RUN with fetch_valid=1
//    (stallf is ignored in BOOT). exc_valid in BOOT is handled as in RUN.
//  Per-edge priority in RUN/PEND: exc_valid > misaligned redirect > redirect > stallf > sequential.
//  exc_valid=1: pcfetch<=EXC_VECTOR, fetch_valid<=1, pending redirect discarded, state<=RUN.
//    Applies regardless of stallf.
//  Misaligned redirect: redirect_valid=1 and redirect_pc[ALIGN_BITS-1:0]!=0.
//    Action: pcfetch<=EXC_VECTOR, badaddr<=redirect_pc, misalign_err<=1 for exactly one cycle,
//    fetch_valid<=1, state<=RUN. Applies regardless of stallf.
//  RUN, redirect_valid=1, stallf=0: pcfetch<=redirect_pc, fetch_valid<=1; 1-cycle redirect latency.
//  RUN, redirect_valid=1, stallf=1: pend_pc<=redirect_pc, pcfetch held,
//    fetch_valid<=0 (wrong-path fetch killed), state<=PEND.
//  RUN, stallf=1, no redirect: pcfetch and fetch_valid held.
//  RUN, stallf=0, no event: pcfetch<=pcfetch+PC_STEP, wrapping modulo 2^XLEN, no flag raised.
//  PEND, stallf=1: hold; fetch_valid stays 0. A new aligned redirect overwrites pend_pc (last wins).
//  PEND, stallf=0, no redirect: pcfetch<=pend_pc, fetch_valid<=1, state<=RUN.
//  PEND, stallf=0, redirect_valid=1: new target wins over pend_pc, state<=RUN.
//  Reset asserted in PEND discards pend_pc; no pending state survives reset.
//  misalign_err is 0 in every cycle not immediately following a trapping edge.
// TESTING
//  1. Reset, stallf=0 for 4 cycles:
//     pcfetch 400030 (valid=0), 400030 (valid=1), 400034, 400038.
//  2. RUN at 400040, redirect_valid=1 to 00400100 with stallf=0:
//     next cycle pcfetch=00400100, then 00400104.
//  3. stallf=1 at 400040, redirect to 00400200, then second redirect to 00400300 while stalled:
//     fetch_valid=0, pcfetch holds 400040. After stall drops: pcfetch=00400300, valid=1.
//  4. Redirect to 00400102 with ALIGN_BITS=2:
//     pcfetch=80000180, misalign_err high for one cycle, badaddr=00400102.
//  5. exc_valid=1 while stallf=1 in PEND:
//     pcfetch=80000180, pend discarded. After stall drops: 80000184, not pend_pc.
//  6. XLEN=32, pcfetch=FFFFFFFC, no stall: next pcfetch=00000000.
//     Reset asserted mid-PEND: pcfetch=RESET_VECTOR, state BOOT, fetch_valid=0.

Source files
------------

// File: rtl/if_pc_unit_if.sv
// Fetch PC control/status bundle between PC-select logic and the fetch PC register.
// No storage; latency belongs to the attached modules.
// No backpressure beyond stallf, which the master drives.
interface if_pc_unit_if #(
    parameter int XLEN = 32
) ();
    logic            stallf;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            exc_valid;
    logic [XLEN-1:0] pcfetch;
    logic [XLEN-1:0] pcplus;
    logic            fetch_valid;
    logic            misalign_err;
    logic [XLEN-1:0] badaddr;

    modport master (
        output stallf, redirect_valid, redirect_pc, exc_valid,
        input  pcfetch, pcplus, fetch_valid, misalign_err, badaddr
    );

    modport slave (
        input  stallf, redirect_valid, redirect_pc, exc_valid,
        output pcfetch, pcplus, fetch_valid, misalign_err, badaddr
    );
endinterface

// File: rtl/if_pc_unit.sv
// Fetch-stage PC: sequential advance, redirects, exceptions, misaligned-target trap.
// Latency: one cycle from any input event to pcfetch; pcplus is combinational.
// Backpressure: stallf holds the PC; a redirect seen under stall is parked until release.
module if_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0040_0030,
    parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int              PC_STEP      = 4,
    parameter int              ALIGN_BITS   = 2
) (
    input  logic          clk,
    input  logic          reset,
    if_pc_unit_if.slave   pc_if
);
    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] pend_q, pend_nxt;
    logic [XLEN-1:0] bad_q, bad_nxt;
    logic            vld_q, vld_nxt;
    logic            err_q, err_nxt;
    logic            misaligned;

    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign misaligned = pc_if.redirect_valid &&
                                (pc_if.redirect_pc[ALIGN_BITS-1:0] != '0);
        end else begin : g_noalign
            assign misaligned = 1'b0;
        end
    endgenerate

    // Redirects arriving in BOOT are not taken; only exceptions act there.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        pend_nxt  = pend_q;
        bad_nxt   = bad_q;
        vld_nxt   = vld_q;
        err_nxt   = 1'b0;
        if (pc_if.exc_valid) begin
            pc_nxt    = EXC_VECTOR;
            vld_nxt   = 1'b1;
            state_nxt = RUN;
        end else if (state == BOOT) begin
            vld_nxt   = 1'b1;
            state_nxt = RUN;
        end else if (misaligned) begin
            pc_nxt    = EXC_VECTOR;
            bad_nxt   = pc_if.redirect_pc;
            err_nxt   = 1'b1;
            vld_nxt   = 1'b1;
            state_nxt = RUN;
        end else if (pc_if.redirect_valid && !pc_if.stallf) begin
            pc_nxt    = pc_if.redirect_pc;
            vld_nxt   = 1'b1;
            state_nxt = RUN;
        end else if (pc_if.redirect_valid) begin
            // Park the target and kill the wrong-path fetch; last redirect wins.
            pend_nxt  = pc_if.redirect_pc;
            vld_nxt   = 1'b0;
            state_nxt = PEND;
        end else if (pc_if.stallf) begin
            state_nxt = state;
        end else if (state == PEND) begin
            pc_nxt    = pend_q;
            vld_nxt   = 1'b1;
            state_nxt = RUN;
        end else begin
            pc_nxt    = pc_q + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= BOOT;
            pc_q   <= RESET_VECTOR;
            pend_q <= '0;
            bad_q  <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_nxt;
            pend_q <= pend_nxt;
            bad_q  <= bad_nxt;
            vld_q  <= vld_nxt;
            err_q  <= err_nxt;
        end
    end

    assign pc_if.pcfetch      = pc_q;
    assign pc_if.pcplus       = pc_q + XLEN'(PC_STEP);
    assign pc_if.fetch_valid  = vld_q;
    assign pc_if.misalign_err = err_q;
    assign pc_if.badaddr      = bad_q;
endmodule

// File: tb/tb_if_pc_unit.sv
// Bench for if_pc_unit: directed scenarios plus random traffic, scoreboarded against a behavioural model.
module tb_if_pc_unit;
    localparam logic [31:0] RV  = 32'h0040_0030;
    localparam logic [31:0] EV  = 32'h8000_0180;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_pc_unit_if #(.XLEN(32)) pif ();

    if_pc_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .PC_STEP(4), .ALIGN_BITS(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pc_if (pif)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] plus;
        logic [31:0] bad;
        logic        vld;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: what the fetch unit should look like after each edge.
    logic [31:0] m_pc = RV, m_bad = '0, m_pend = '0;
    logic        m_vld = 1'b0, m_err = 1'b0, m_boot = 1'b1, m_haspend = 1'b0;

    task automatic model_edge(input bit rst, input bit st, input bit rv,
                              input logic [31:0] rpc, input bit ex);
        logic [1:0] low;
        low   = rpc[1:0];
        m_err = 1'b0;
        if (rst) begin
            m_pc = RV; m_vld = 1'b0; m_bad = '0; m_boot = 1'b1; m_haspend = 1'b0;
        end else if (ex) begin
            m_pc = EV; m_vld = 1'b1; m_boot = 1'b0; m_haspend = 1'b0;
        end else if (m_boot) begin
            m_vld = 1'b1; m_boot = 1'b0;
        end else if (rv && low != 2'b00) begin
            m_pc = EV; m_bad = rpc; m_err = 1'b1; m_vld = 1'b1; m_haspend = 1'b0;
        end else if (rv && !st) begin
            m_pc = rpc; m_vld = 1'b1; m_haspend = 1'b0;
        end else if (rv) begin
            m_pend = rpc; m_haspend = 1'b1; m_vld = 1'b0;
        end else if (st) begin
            m_pc = m_pc;
        end else if (m_haspend) begin
            m_pc = m_pend; m_vld = 1'b1; m_haspend = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit rv,
                        input logic [31:0] rpc, input bit ex);
        exp_t e;
        @(negedge clk);
        reset              = rst;
        pif.stallf         = st;
        pif.redirect_valid = rv;
        pif.redirect_pc    = rpc;
        pif.exc_valid      = ex;
        model_edge(rst, st, rv, rpc, ex);
        e.pc   = m_pc;
        e.plus = m_pc + 32'd4;
        e.bad  = m_bad;
        e.vld  = m_vld;
        e.err  = m_err;
        sb_q.push_back(e);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: the DUT presents a fresh output set after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check32("pcfetch",      pif.pcfetch,              e.pc);
                check32("pcplus",       pif.pcplus,               e.plus);
                check32("fetch_valid",  {31'd0, pif.fetch_valid},  {31'd0, e.vld});
                check32("misalign_err", {31'd0, pif.misalign_err}, {31'd0, e.err});
                check32("badaddr",      pif.badaddr,              e.bad);
            end
        end
    end

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        int          k;
        r = $urandom();
        k = $urandom_range(0, 7);
        if (k == 0)      r = 32'hFFFF_FFFC;
        else if (k == 1) r[1:0] = 2'($urandom_range(1, 3));
        else             r[1:0] = 2'b00;
        return r;
    endfunction

    initial begin
        reset              = 1'b1;
        pif.stallf         = 1'b0;
        pif.redirect_valid = 1'b0;
        pif.redirect_pc    = '0;
        pif.exc_valid      = 1'b0;

        // Reset and boot, then sequential fetch up to 400040.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        // Unstalled redirect.
        step(0, 0, 1, 32'h0040_0100, 0);
        step(0, 0, 0, 0, 0);
        // Redirect under stall, overwritten by a second one, then released.
        step(0, 0, 1, 32'h0040_0040, 0);
        step(0, 1, 1, 32'h0040_0200, 0);
        step(0, 1, 1, 32'h0040_0300, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Misaligned redirect trap, pulse drops afterwards.
        step(0, 0, 1, 32'h0040_0102, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Exception while pending under stall discards the parked target.
        step(0, 1, 1, 32'h0040_0500, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Misaligned redirect while pending and stalled.
        step(0, 1, 1, 32'h0040_0600, 0);
        step(0, 1, 1, 32'h0040_0603, 0);
        step(0, 0, 0, 0, 0);
        // Exception beats a simultaneous misaligned redirect.
        step(0, 0, 1, 32'h1234_5671, 1);
        step(0, 0, 0, 0, 0);
        // Wrap-around at the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Reset while pending, then boot with stall held (stall ignored in boot).
        step(0, 1, 1, 32'h0040_0700, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            bit rst, st, rv, ex;
            rst = ($urandom_range(0, 63) == 0);
            st  = ($urandom_range(0, 9) < 4);
            rv  = ($urandom_range(0, 4) == 0) && !m_boot;
            ex  = ($urandom_range(0, 19) == 0);
            step(rst, st, rv, rand_target(), ex);
        end

        step(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check32("scoreboard_drain", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
